rtc_time_counter: RTL and testbench

Parametrised real-time clock core that derives its 1 Hz timebase from the system clock and keeps BCD hours, minutes and seconds. Hours are kept internally in 24 h form, with a 12 h/24 h display mode and a PM flag. Set mode adjusts one field at a time, with wrap-around in both directions and no carry. A single-time hh:mm alarm raises a sticky flag. It feeds the display/segment driver and the alarm buzzer logic.

---
 rtl/rtc_time_counter.sv | 132 +++++++++++++
 tb/tb_rtc_time_counter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_time_counter.sv
// BCD hh:mm:ss real-time clock with a CLK_HZ prescaler timebase, a set mode that
// adjusts one field at a time, 12 h/24 h display mapping and a sticky hh:mm alarm.
module rtc_time_counter #(
   parameter int unsigned CLK_HZ   = 50000000,
   parameter bit          ALARM_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_12h,
   input  logic       set,
   input  logic       up,
   input  logic       down,
   input  logic [1:0] field,
   input  logic [7:0] alarm_hh,
   input  logic [7:0] alarm_mm,
   input  logic       alarm_arm,
   input  logic       alarm_clr,
   output logic [7:0] sec_o,
   output logic [7:0] min_o,
   output logic [7:0] hour_o,
   output logic       pm_o,
   output logic       tick_o,
   output logic       alarm_flag
);

   localparam int unsigned PW = $clog2(CLK_HZ);
   localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

   logic [PW-1:0] pre_q, pre_d;
   logic [7:0]    sec_q, sec_d;
   logic [7:0]    min_q, min_d;
   logic [7:0]    hour_q, hour_d;
   logic          tick_q, tick_d;
   logic          alarm_q, alarm_d;
   logic          match;
   logic [4:0]    hour_bin;
   logic [4:0]    hour12_bin;
   logic [4:0]    hour12_ones;
   logic          hour12_tens;

   // BCD +1 / -1 with wrap at max; digits always stay in 0-9
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      logic [7:0] r;
      if (v == max)              r = 8'h00;
      else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
      else                       r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
      logic [7:0] r;
      if (v == 8'h00)            r = max;
      else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
      else                       r = {v[7:4], v[3:0] - 4'd1};
      return r;
   endfunction

   // Internal registers are always valid BCD, so an invalid alarm setting can never match
   assign match = tick_q && alarm_arm && (sec_q == 8'h00) &&
                  (min_q == alarm_mm) && (hour_q == alarm_hh);

   always_comb begin
      pre_d   = pre_q;
      sec_d   = sec_q;
      min_d   = min_q;
      hour_d  = hour_q;
      tick_d  = 1'b0;
      alarm_d = alarm_q;

      if (set) begin
         pre_d = '0;
         if (up ^ down) begin
            case (field)
               2'd0:    sec_d  = up ? bcd_inc(sec_q, 8'h59)  : bcd_dec(sec_q, 8'h59);
               2'd1:    min_d  = up ? bcd_inc(min_q, 8'h59)  : bcd_dec(min_q, 8'h59);
               2'd2:    hour_d = up ? bcd_inc(hour_q, 8'h23) : bcd_dec(hour_q, 8'h23);
               default: sec_d  = 8'h00;
            endcase
         end
      end else if (pre_q == PRE_MAX) begin
         pre_d  = '0;
         tick_d = 1'b1;
         sec_d  = bcd_inc(sec_q, 8'h59);
         if (sec_q == 8'h59) begin
            min_d = bcd_inc(min_q, 8'h59);
            if (min_q == 8'h59) hour_d = bcd_inc(hour_q, 8'h23);
         end
      end else begin
         pre_d = pre_q + PW'(1);
      end

      if (!ALARM_EN)       alarm_d = 1'b0;
      else if (match)      alarm_d = 1'b1;
      else if (alarm_clr)  alarm_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q   <= '0;
         sec_q   <= 8'h00;
         min_q   <= 8'h00;
         hour_q  <= 8'h00;
         tick_q  <= 1'b0;
         alarm_q <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         hour_q  <= hour_d;
         tick_q  <= tick_d;
         alarm_q <= alarm_d;
      end
   end

   // 12 h map: 00 -> 12, 13-23 -> 01-11
   always_comb begin
      hour_bin = 5'(hour_q[7:4]) * 5'd10 + 5'(hour_q[3:0]);
      if (hour_bin == 5'd0)       hour12_bin = 5'd12;
      else if (hour_bin > 5'd12)  hour12_bin = hour_bin - 5'd12;
      else                        hour12_bin = hour_bin;
      hour12_tens = (hour12_bin >= 5'd10);
      hour12_ones = hour12_tens ? hour12_bin - 5'd10 : hour12_bin;
   end

   assign sec_o      = sec_q;
   assign min_o      = min_q;
   assign hour_o     = mode_12h ? {3'b000, hour12_tens, hour12_ones[3:0]} : hour_q;
   assign pm_o       = (hour_q >= 8'h12);
   assign tick_o     = tick_q;
   assign alarm_flag = alarm_q;

endmodule

// File: tb/tb_rtc_time_counter.sv
// Self-checking bench for rtc_time_counter: vector table, directed corner sequences and a
// randomized run against a seconds-of-day reference model.
module tb_rtc_time_counter;

   localparam int unsigned CLK_HZ = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode_12h = 1'b0;
   logic       set = 1'b0;
   logic       up = 1'b0;
   logic       down = 1'b0;
   logic [1:0] field = 2'd0;
   logic [7:0] alarm_hh = 8'h00;
   logic [7:0] alarm_mm = 8'h00;
   logic       alarm_arm = 1'b0;
   logic       alarm_clr = 1'b0;
   logic [7:0] sec_o, min_o, hour_o;
   logic       pm_o, tick_o, alarm_flag;

   int checks = 0;
   int errors = 0;

   // reference state
   int m_sod = 0;
   int m_pre = 0;
   bit m_tick = 1'b0;
   bit m_flag = 1'b0;

   always #5 clk = ~clk;

   rtc_time_counter #(.CLK_HZ(CLK_HZ), .ALARM_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .mode_12h(mode_12h), .set(set), .up(up), .down(down),
      .field(field), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_arm(alarm_arm),
      .alarm_clr(alarm_clr), .sec_o(sec_o), .min_o(min_o), .hour_o(hour_o), .pm_o(pm_o),
      .tick_o(tick_o), .alarm_flag(alarm_flag)
   );

   typedef struct {
      logic [1:0] fld;
      logic       u;
      logic       d;
      logic [7:0] e_hour;
      logic [7:0] e_min;
      logic [7:0] e_sec;
   } vec_t;
   vec_t vecs[10];

   function automatic logic [7:0] to_bcd(input int x);
      return 8'((x / 10) * 16 + (x % 10));
   endfunction

   function automatic int from_bcd(input logic [7:0] v);
      if (v[7:4] > 4'd9 || v[3:0] > 4'd9) return -1;
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int h, m, s, ah, am;
      bit match;
      if (rst) begin
         m_sod = 0; m_pre = 0; m_tick = 1'b0; m_flag = 1'b0;
         return;
      end
      h = m_sod / 3600; m = (m_sod / 60) % 60; s = m_sod % 60;
      ah = from_bcd(alarm_hh); am = from_bcd(alarm_mm);
      match = m_tick && alarm_arm && s == 0 && ah == h && am == m;
      if (match) m_flag = 1'b1;
      else if (alarm_clr) m_flag = 1'b0;
      if (set) begin
         m_pre = 0; m_tick = 1'b0;
         if (up != down) begin
            case (field)
               2'd0: s = up ? (s + 1) % 60 : (s + 59) % 60;
               2'd1: m = up ? (m + 1) % 60 : (m + 59) % 60;
               2'd2: h = up ? (h + 1) % 24 : (h + 23) % 24;
               default: s = 0;
            endcase
            m_sod = h * 3600 + m * 60 + s;
         end
      end else if (m_pre == CLK_HZ - 1) begin
         m_pre = 0; m_tick = 1'b1; m_sod = (m_sod + 1) % 86400;
      end else begin
         m_pre++; m_tick = 1'b0;
      end
   endtask

   task automatic check_model();
      int h;
      h = m_sod / 3600;
      chk("m_sec", sec_o, to_bcd(m_sod % 60));
      chk("m_min", min_o, to_bcd((m_sod / 60) % 60));
      chk("m_hour", hour_o, mode_12h ? to_bcd((h % 12 == 0) ? 12 : h % 12) : to_bcd(h));
      chk("m_pm", {7'd0, pm_o}, {7'd0, h >= 12});
      chk("m_tick", {7'd0, tick_o}, {7'd0, m_tick});
      chk("m_flag", {7'd0, alarm_flag}, {7'd0, m_flag});
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic adj(input logic [1:0] f, input logic u, input logic d);
      field = f; up = u; down = d;
      cyc();
      up = 1'b0; down = 1'b0;
   endtask

   task automatic chk_time(input string name, input logic [7:0] hh, input logic [7:0] mm,
                           input logic [7:0] ss);
      chk({name, "_hour"}, hour_o, hh);
      chk({name, "_min"}, min_o, mm);
      chk({name, "_sec"}, sec_o, ss);
   endtask

   initial begin
      vecs[0] = '{2'd0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h59};
      vecs[1] = '{2'd0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
      vecs[2] = '{2'd2, 1'b0, 1'b1, 8'h23, 8'h00, 8'h00};
      vecs[3] = '{2'd2, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00};
      vecs[4] = '{2'd2, 1'b0, 1'b1, 8'h23, 8'h00, 8'h00};
      vecs[5] = '{2'd1, 1'b1, 1'b1, 8'h23, 8'h00, 8'h00};
      vecs[6] = '{2'd1, 1'b0, 1'b1, 8'h23, 8'h59, 8'h00};
      vecs[7] = '{2'd0, 1'b0, 1'b1, 8'h23, 8'h59, 8'h59};
      vecs[8] = '{2'd3, 1'b1, 1'b0, 8'h23, 8'h59, 8'h00};
      vecs[9] = '{2'd0, 1'b0, 1'b0, 8'h23, 8'h59, 8'h00};

      // reset state and first ticks
      repeat (2) cyc();
      chk_time("rst", 8'h00, 8'h00, 8'h00);
      chk("rst_pm", {7'd0, pm_o}, 8'h00);
      chk("rst_tick", {7'd0, tick_o}, 8'h00);
      chk("rst_flag", {7'd0, alarm_flag}, 8'h00);
      mode_12h = 1'b1; #1;
      chk("rst_h12", hour_o, 8'h12);
      mode_12h = 1'b0;
      rst = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         cyc();
         chk("t1_tick", {7'd0, tick_o}, {7'd0, c % 4 == 0});
         chk("t1_sec", sec_o, to_bcd(c / 4));
      end

      // set-mode vector table from 00:00:00
      rst = 1'b1; cyc(); rst = 1'b0;
      set = 1'b1;
      for (int i = 0; i < 10; i++) begin
         adj(vecs[i].fld, vecs[i].u, vecs[i].d);
         chk_time($sformatf("vec%0d", i), vecs[i].e_hour, vecs[i].e_min, vecs[i].e_sec);
      end
      repeat (8) cyc();
      chk("set_hold_sec", sec_o, 8'h00);
      up = 1'b1; set = 1'b0; cyc(); up = 1'b0;
      chk("up_ignored", sec_o, 8'h00);

      // 23:59:59 -> 00:00:00, then 11:59:59 -> 12:00:00
      set = 1'b1; adj(2'd0, 1'b0, 1'b1);
      chk_time("t2a", 8'h23, 8'h59, 8'h59);
      set = 1'b0; mode_12h = 1'b1;
      repeat (4) cyc();
      chk_time("t2b", 8'h12, 8'h00, 8'h00);
      chk("t2b_pm", {7'd0, pm_o}, 8'h00);
      chk("t2b_tick", {7'd0, tick_o}, 8'h01);
      set = 1'b1;
      repeat (11) adj(2'd2, 1'b1, 1'b0);
      adj(2'd1, 1'b0, 1'b1); adj(2'd0, 1'b0, 1'b1);
      chk_time("t2c", 8'h11, 8'h59, 8'h59);
      set = 1'b0;
      repeat (4) cyc();
      chk_time("t2d", 8'h12, 8'h00, 8'h00);
      chk("t2d_pm", {7'd0, pm_o}, 8'h01);
      mode_12h = 1'b0; #1;
      chk("t2d_h24", hour_o, 8'h12);

      // alarm 07:30
      alarm_hh = 8'h07; alarm_mm = 8'h30; alarm_arm = 1'b1;
      set = 1'b1;
      repeat (5) adj(2'd2, 1'b0, 1'b1);
      repeat (29) adj(2'd1, 1'b1, 1'b0);
      adj(2'd0, 1'b0, 1'b1);
      chk_time("t4a", 8'h07, 8'h29, 8'h59);
      set = 1'b0;
      repeat (3) cyc();
      chk("t4_pretick", {7'd0, tick_o}, 8'h00);
      cyc();
      chk("t4_tick", {7'd0, tick_o}, 8'h01);
      chk("t4_flag_early", {7'd0, alarm_flag}, 8'h00);
      cyc();
      chk("t4_flag", {7'd0, alarm_flag}, 8'h01);
      alarm_arm = 1'b0; cyc();
      chk("t4_disarm_keeps", {7'd0, alarm_flag}, 8'h01);
      alarm_arm = 1'b1; alarm_clr = 1'b1; cyc(); alarm_clr = 1'b0;
      chk("t4_clr", {7'd0, alarm_flag}, 8'h00);
      set = 1'b1; adj(2'd1, 1'b0, 1'b1); adj(2'd3, 1'b1, 1'b0); adj(2'd0, 1'b0, 1'b1);
      set = 1'b0;
      repeat (4) cyc();
      chk("t4_tick2", {7'd0, tick_o}, 8'h01);
      alarm_clr = 1'b1; cyc(); alarm_clr = 1'b0;
      chk("t4_match_wins", {7'd0, alarm_flag}, 8'h01);

      // set-mode adjustments at 07:30:00 never raise the flag
      alarm_clr = 1'b1; cyc(); alarm_clr = 1'b0;
      set = 1'b1;
      adj(2'd3, 1'b1, 1'b0);
      chk_time("t5a", 8'h07, 8'h30, 8'h00);
      for (int i = 0; i < 8; i++) begin
         adj((i % 4 == 3) ? 2'd3 : 2'd0, 1'(i % 2), 1'((i + 1) % 2));
         cyc();
         chk("t5_noflag", {7'd0, alarm_flag}, 8'h00);
      end
      set = 1'b0;
      repeat (2) cyc();
      rst = 1'b1; cyc(); rst = 1'b0;
      chk_time("t5_rst", 8'h00, 8'h00, 8'h00);
      chk("t5_rst_flag", {7'd0, alarm_flag}, 8'h00);
      for (int c = 1; c <= 4; c++) begin
         cyc();
         chk("t5_tick", {7'd0, tick_o}, {7'd0, c == 4});
      end

      // randomized run against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 2) set = ~set;
         up = ($urandom_range(0, 3) == 0);
         down = ($urandom_range(0, 3) == 0);
         field = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 99) == 0) mode_12h = ~mode_12h;
         alarm_clr = ($urandom_range(0, 49) == 0);
         alarm_arm = ($urandom_range(0, 9) != 0);
         rst = ($urandom_range(0, 999) == 0);
         if (i % 200 == 0) begin
            if ($urandom_range(0, 4) == 0) begin
               alarm_hh = 8'h2A; alarm_mm = 8'h7F;
            end else begin
               alarm_hh = to_bcd((((m_sod / 60) + 1) / 60) % 24);
               alarm_mm = to_bcd(((m_sod / 60) + 1) % 60);
            end
         end
         cyc();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
